// File: rtl/addr_trans_mmu_pkg.sv
// Shared definitions for the address translation unit: segment codes,
// page-table entry layout and the VPN/PFN width helper.
package addr_trans_pkg;

  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;

  // Fields are held at full address width; the top zero-extends the
  // VW-bit stored values so the lookup never depends on PAGE_BITS for layout.
  typedef struct packed {
    logic [31:0] vpn;
    logic [31:0] pfn;
    logic        v;
  } tbl_entry_t;

  function automatic int vw_of(input int page_bits);
    return 32 - page_bits;
  endfunction

endpackage

// File: rtl/addr_trans_mmu_lookup.sv
// Combinational translation of one virtual address: segment decode,
// fully associative page match and lowest-index priority select.
module addr_trans_lookup
  import addr_trans_pkg::*;
#(
  parameter int ENTRIES   = 8,
  parameter int PAGE_BITS = 12
) (
  input  logic [31:0] vaddr_i,
  input  logic        mapped_i,
  input  tbl_entry_t  tbl_i [ENTRIES],
  output logic [31:0] paddr_o,
  output logic        uncached_o,
  output logic        miss_o
);

  localparam logic [31:0] OFF_MASK = (32'd1 << PAGE_BITS) - 32'd1;

  logic [2:0]  seg;
  logic [31:0] vpn_w;
  logic        hit;
  logic [31:0] hit_pfn;

  assign seg   = vaddr_i[31:29];
  assign vpn_w = vaddr_i >> PAGE_BITS;

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit     = 1'b0;
    hit_pfn = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (tbl_i[i].v && (tbl_i[i].vpn == vpn_w)) begin
        hit     = 1'b1;
        hit_pfn = tbl_i[i].pfn;
      end
    end
  end

  always_comb begin
    paddr_o    = vaddr_i;
    uncached_o = 1'b0;
    miss_o     = 1'b0;
    if ((seg == KSEG0) || (seg == KSEG1)) begin
      paddr_o    = {3'b000, vaddr_i[28:0]};
      uncached_o = (seg == KSEG1);
    end else if (mapped_i) begin
      if (hit) begin
        paddr_o = (hit_pfn << PAGE_BITS) | (vaddr_i & OFF_MASK);
      end else begin
        miss_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addr_trans_mmu.sv
// Multi-channel virtual-to-physical translation unit: shared page table
// written from the CP0 side, one lookup and one response register per channel.
module addr_trans_mmu
  import addr_trans_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int ENTRIES   = 8,
  parameter  int PAGE_BITS = 12,
  localparam int VW        = vw_of(PAGE_BITS),
  localparam int IW        = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mapped,
  input  logic [NUM_CH-1:0]   req_valid,
  output logic [NUM_CH-1:0]   req_ready,
  input  logic [NUM_CH*32-1:0] req_vaddr,
  output logic [NUM_CH-1:0]   rsp_valid,
  input  logic [NUM_CH-1:0]   rsp_ready,
  output logic [NUM_CH*32-1:0] rsp_paddr,
  output logic [NUM_CH-1:0]   rsp_uncached,
  output logic [NUM_CH-1:0]   rsp_miss,
  input  logic                tbl_we,
  input  logic [IW-1:0]       tbl_idx,
  input  logic [VW-1:0]       tbl_vpn,
  input  logic [VW-1:0]       tbl_pfn,
  input  logic                tbl_v,
  input  logic                tbl_flush
);

  // Page table: valid bits are reset, VPN/PFN storage is not.
  logic [ENTRIES-1:0] tv_q, tv_d;
  logic [VW-1:0]      vpn_q [ENTRIES];
  logic [VW-1:0]      pfn_q [ENTRIES];
  tbl_entry_t         tbl   [ENTRIES];

  always_comb begin
    tv_d = tbl_flush ? '0 : tv_q;
    if (tbl_we) tv_d[tbl_idx] = tbl_v;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tv_q <= '0;
    else         tv_q <= tv_d;
  end

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      vpn_q[tbl_idx] <= tbl_vpn;
      pfn_q[tbl_idx] <= tbl_pfn;
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      tbl[i].vpn = 32'(vpn_q[i]);
      tbl[i].pfn = 32'(pfn_q[i]);
      tbl[i].v   = tv_q[i];
    end
  end

  logic [NUM_CH*32-1:0] xl_paddr;
  logic [NUM_CH-1:0]    xl_unc, xl_miss;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    addr_trans_lookup #(
      .ENTRIES   (ENTRIES),
      .PAGE_BITS (PAGE_BITS)
    ) u_lookup (
      .vaddr_i    (req_vaddr[32*c +: 32]),
      .mapped_i   (mapped),
      .tbl_i      (tbl),
      .paddr_o    (xl_paddr[32*c +: 32]),
      .uncached_o (xl_unc[c]),
      .miss_o     (xl_miss[c])
    );
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The response slot is free when empty or being drained this cycle, so a
  // channel sustains one request per cycle while rsp_ready stays high.
  logic [NUM_CH-1:0]    valid_q, valid_d, unc_q, unc_d, miss_q, miss_d, accept;
  logic [NUM_CH*32-1:0] paddr_q, paddr_d;

  assign req_ready = ~valid_q | rsp_ready;
  assign accept    = req_valid & req_ready;

  always_comb begin
    valid_d = (valid_q & ~rsp_ready) | accept;
    paddr_d = paddr_q;
    unc_d   = unc_q;
    miss_d  = miss_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (accept[c]) begin
        paddr_d[32*c +: 32] = xl_paddr[32*c +: 32];
        unc_d[c]            = xl_unc[c];
        miss_d[c]           = xl_miss[c];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      paddr_q <= '0;
      unc_q   <= '0;
      miss_q  <= '0;
    end else begin
      valid_q <= valid_d;
      paddr_q <= paddr_d;
      unc_q   <= unc_d;
      miss_q  <= miss_d;
    end
  end

  assign rsp_valid    = valid_q;
  assign rsp_paddr    = paddr_q;
  assign rsp_uncached = unc_q;
  assign rsp_miss     = miss_q;

endmodule

// File: tb/tb_addr_trans_mmu.sv
// Bench for addr_trans_mmu: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_addr_trans_mmu;

  localparam int NUM_CH = 2;
  localparam int ENTRIES = 8;
  localparam int PAGE_BITS = 12;
  localparam int VW = 20;
  localparam int IW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic                 mapped = 1'b0;
  logic [NUM_CH-1:0]    req_valid = '0, rsp_ready = '0;
  logic [NUM_CH-1:0]    req_ready, rsp_valid, rsp_uncached, rsp_miss;
  logic [NUM_CH*32-1:0] req_vaddr = '0, rsp_paddr;
  logic                 tbl_we = 1'b0, tbl_flush = 1'b0, tbl_v = 1'b0;
  logic [IW-1:0]        tbl_idx = '0;
  logic [VW-1:0]        tbl_vpn = '0, tbl_pfn = '0;

  addr_trans_mmu #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .PAGE_BITS(PAGE_BITS)) dut (
    .clk(clk), .resetn(resetn), .mapped(mapped),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_paddr(rsp_paddr),
    .rsp_uncached(rsp_uncached), .rsp_miss(rsp_miss),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_vpn(tbl_vpn), .tbl_pfn(tbl_pfn),
    .tbl_v(tbl_v), .tbl_flush(tbl_flush)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int ch, input logic [33:0] act, input logic [33:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s ch%0d: got %h expected %h (t=%0t)", nm, ch, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pa(input int c);
    return rsp_paddr[32*c +: 32];
  endfunction

  // ---------------- behavioural model ----------------
  logic [ENTRIES-1:0]    m_tv;
  logic [ENTRIES*20-1:0] m_vpn, m_pfn;
  logic                  m_rv  [NUM_CH];
  logic [31:0]           m_pa  [NUM_CH];
  logic                  m_unc [NUM_CH];
  logic                  m_miss[NUM_CH];
  logic [33:0]           m_x   [NUM_CH];
  logic [33:0]           exp_q0[$];
  logic [33:0]           exp_q1[$];

  // Result packed as {miss, uncached, paddr}.
  function automatic logic [33:0] ref_xlate(input logic [31:0] va, input logic mp,
                                             input logic [ENTRIES-1:0] tv,
                                             input logic [ENTRIES*20-1:0] vpn,
                                             input logic [ENTRIES*20-1:0] pfn);
    if (va[31:29] == 3'b100) return {2'b00, 3'b000, va[28:0]};
    if (va[31:29] == 3'b101) return {2'b01, 3'b000, va[28:0]};
    if (!mp) return {2'b00, va};
    for (int i = 0; i < ENTRIES; i++)
      if (tv[i] && (vpn[20*i +: 20] == va[31:12])) return {2'b00, pfn[20*i +: 20], va[11:0]};
    return {2'b10, va};
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      m_x[c] = ref_xlate(req_vaddr[32*c +: 32], mapped, m_tv, m_vpn, m_pfn);
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_tv <= '0;
      for (int c = 0; c < NUM_CH; c++) m_rv[c] <= 1'b0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (req_valid[c] && (!m_rv[c] || rsp_ready[c])) begin
          m_rv[c]   <= 1'b1;
          m_pa[c]   <= m_x[c][31:0];
          m_unc[c]  <= m_x[c][32];
          m_miss[c] <= m_x[c][33];
          if (c == 0) exp_q0.push_back(m_x[c]);
          else        exp_q1.push_back(m_x[c]);
        end else if (rsp_ready[c]) begin
          m_rv[c] <= 1'b0;
        end
      end
      if (tbl_flush) m_tv <= '0;
      if (tbl_we) begin
        m_tv[tbl_idx]            <= tbl_v;
        m_vpn[20*tbl_idx +: 20]  <= tbl_vpn;
        m_pfn[20*tbl_idx +: 20]  <= tbl_pfn;
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  logic [33:0] sb_front;
  logic        sb_have;

  always @(negedge clk) begin
    if (resetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        chk("rsp_valid", c, 34'(rsp_valid[c]), 34'(m_rv[c]));
        chk("req_ready", c, 34'(req_ready[c]), 34'(!m_rv[c] || rsp_ready[c]));
        if (m_rv[c]) begin
          chk("rsp_paddr", c, 34'(pa(c)), 34'(m_pa[c]));
          chk("rsp_uncached", c, 34'(rsp_uncached[c]), 34'(m_unc[c]));
          chk("rsp_miss", c, 34'(rsp_miss[c]), 34'(m_miss[c]));
        end
        if (rsp_valid[c] && rsp_ready[c]) begin
          sb_have = (c == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
          chk("sb_nonempty", c, 34'(sb_have), 34'd1);
          if (sb_have) begin
            if (c == 0) sb_front = exp_q0.pop_front();
            else        sb_front = exp_q1.pop_front();
            chk("scoreboard", c, {rsp_miss[c], rsp_uncached[c], pa(c)}, sb_front);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic v, input logic [31:0] a);
    req_valid[c]          = v;
    req_vaddr[32*c +: 32] = a;
  endtask

  task automatic tbl_write(input int idx, input logic [19:0] vpn, input logic [19:0] pfn, input logic v);
    tbl_we  = 1'b1;
    tbl_idx = IW'(idx);
    tbl_vpn = vpn;
    tbl_pfn = pfn;
    tbl_v   = v;
  endtask

  logic [19:0] pool [4];

  initial begin
    pool[0] = 20'h00400; pool[1] = 20'h7FFFF; pool[2] = 20'hC0010; pool[3] = 20'h00001;

    // reset
    resetn = 1'b0;
    repeat (3) cyc();
    resetn = 1'b1;
    cyc();
    chk("reset_valid", 0, 34'(rsp_valid), 34'd0);
    chk("reset_paddr", 0, 34'(rsp_paddr), 34'd0);
    chk("reset_unc_miss", 0, 34'({rsp_uncached, rsp_miss}), 34'd0);
    chk("reset_ready", 0, 34'(req_ready), 34'h3);

    // kseg0 / kseg1 unmapped window, both channels in the same cycle
    mapped = 1'b0;
    rsp_ready = 2'b11;
    set_req(0, 1'b1, 32'h9FC0_0000);
    set_req(1, 1'b1, 32'hBFC0_0100);
    cyc();
    chk("kseg0_paddr", 0, 34'(pa(0)), 34'h1FC0_0000);
    chk("kseg0_unc", 0, 34'(rsp_uncached[0]), 34'd0);
    chk("kseg1_paddr", 1, 34'(pa(1)), 34'h1FC0_0100);
    chk("kseg1_unc", 1, 34'(rsp_uncached[1]), 34'd1);
    chk("model_kseg1", 1, 34'(m_pa[1]), 34'h1FC0_0100);
    set_req(0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0);

    // mapped hit and miss
    mapped = 1'b1;
    tbl_write(3, 20'h00400, 20'h01234, 1'b1);
    cyc();
    tbl_we = 1'b0;
    set_req(0, 1'b1, 32'h0040_0ABC);
    cyc();
    chk("map_hit_paddr", 0, 34'(pa(0)), 34'h0123_4ABC);
    chk("map_hit_miss", 0, 34'(rsp_miss[0]), 34'd0);
    set_req(0, 1'b1, 32'h0050_0000);
    cyc();
    chk("map_miss_paddr", 0, 34'(pa(0)), 34'h0050_0000);
    chk("map_miss_flag", 0, 34'(rsp_miss[0]), 34'd1);
    chk("model_miss", 0, 34'(m_miss[0]), 34'd1);
    set_req(0, 1'b0, 32'h0);
    cyc();

    // backpressure on ch0
    rsp_ready[0] = 1'b0;
    set_req(0, 1'b1, 32'h8000_1000);
    cyc();
    chk("bp_first", 0, 34'(pa(0)), 34'h0000_1000);
    set_req(0, 1'b1, 32'h8000_2000);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_ready_low", 0, 34'(req_ready[0]), 34'd0);
      chk("bp_stable", 0, 34'(pa(0)), 34'h0000_1000);
    end
    rsp_ready[0] = 1'b1;
    cyc();
    chk("bp_release", 0, 34'(pa(0)), 34'h0000_2000);
    set_req(0, 1'b1, 32'h8000_3000);
    cyc();
    chk("bp_next", 0, 34'(pa(0)), 34'h0000_3000);
    set_req(0, 1'b0, 32'h0);
    cyc();

    // table write in the same cycle as a lookup is not yet visible
    tbl_flush = 1'b1;
    cyc();
    tbl_flush = 1'b0;
    tbl_write(0, 20'h00400, 20'h00AAA, 1'b1);
    set_req(0, 1'b1, 32'h0040_0000);
    cyc();
    tbl_we = 1'b0;
    chk("same_cyc_miss", 0, 34'(rsp_miss[0]), 34'd1);
    chk("same_cyc_paddr", 0, 34'(pa(0)), 34'h0040_0000);
    cyc();
    chk("next_cyc_paddr", 0, 34'(pa(0)), 34'h00AA_A000);
    chk("next_cyc_miss", 0, 34'(rsp_miss[0]), 34'd0);
    set_req(0, 1'b0, 32'h0);

    // multiple hits: lowest index wins; flush clears
    tbl_write(2, 20'h7FFFF, 20'h00002, 1'b1);
    cyc();
    tbl_write(5, 20'h7FFFF, 20'h00005, 1'b1);
    cyc();
    tbl_we = 1'b0;
    set_req(0, 1'b1, 32'h7FFF_F010);
    cyc();
    chk("prio_low_idx", 0, 34'(pa(0)), 34'h0000_2010);
    set_req(0, 1'b0, 32'h0);
    tbl_flush = 1'b1;
    cyc();
    tbl_flush = 1'b0;
    set_req(0, 1'b1, 32'h7FFF_F010);
    cyc();
    chk("flush_miss", 0, 34'(rsp_miss[0]), 34'd1);
    chk("flush_paddr", 0, 34'(pa(0)), 34'h7FFF_F010);
    set_req(0, 1'b0, 32'h0);
    cyc();

    // asynchronous reset with pending responses
    tbl_write(1, 20'h7FFFF, 20'h00077, 1'b1);
    cyc();
    tbl_we = 1'b0;
    rsp_ready = 2'b00;
    set_req(0, 1'b1, 32'h8000_0040);
    set_req(1, 1'b1, 32'hA000_0080);
    cyc();
    chk("pre_reset_valid", 0, 34'(rsp_valid), 34'h3);
    set_req(0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_valid", 0, 34'(rsp_valid), 34'd0);
    chk("async_reset_paddr", 0, 34'(rsp_paddr), 34'd0);
    chk("model_async_reset", 0, 34'(m_rv[0]), 34'd0);
    cyc();
    cyc();
    resetn = 1'b1;
    rsp_ready = 2'b11;
    cyc();
    chk("post_reset_idle", 0, 34'(rsp_valid), 34'd0);
    set_req(0, 1'b1, 32'h7FFF_F010);
    cyc();
    chk("post_reset_tbl_empty", 0, 34'(rsp_miss[0]), 34'd1);
    set_req(0, 1'b0, 32'h0);
    cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        logic [31:0] a;
        case ($urandom_range(0, 5))
          0:       a = {3'b100, 29'($urandom)};
          1:       a = {3'b101, 29'($urandom)};
          2, 3:    a = {pool[$urandom_range(0, 3)], 12'($urandom)};
          default: a = $urandom;
        endcase
        set_req(c, ($urandom_range(0, 3) != 0), a);
        rsp_ready[c] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 15) == 0) mapped = ~mapped;
      tbl_we    = ($urandom_range(0, 3) == 0);
      tbl_idx   = IW'($urandom_range(0, ENTRIES - 1));
      tbl_vpn   = pool[$urandom_range(0, 3)];
      tbl_pfn   = 20'($urandom);
      tbl_v     = ($urandom_range(0, 4) != 0);
      tbl_flush = ($urandom_range(0, 31) == 0);
      cyc();
    end

    // drain
    req_valid = '0;
    rsp_ready = 2'b11;
    tbl_we = 1'b0;
    tbl_flush = 1'b0;
    repeat (3) cyc();
    chk("drain_q0", 0, 34'(exp_q0.size()), 34'd0);
    chk("drain_q1", 1, 34'(exp_q1.size()), 34'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
